// File: rtl/apb_master_bridge_if.sv
// Command/response handshake and APB segment signals for apb_master_bridge.
// The master modport is the bridge's view; the slave modport is the fabric/peripheral side.
interface apb_master_bridge_if #(
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 32,
  parameter int NUM_SLAVES = 4
);
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic                           cmd_write;
  logic [PADDR_SIZE-1:0]          cmd_addr;
  logic [PDATA_SIZE-1:0]          cmd_wdata;
  logic [PDATA_SIZE/8-1:0]        cmd_strb;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [PDATA_SIZE-1:0]          rsp_rdata;
  logic                           rsp_err;
  logic                           rsp_timeout;
  logic [NUM_SLAVES-1:0]          PSEL;
  logic                           PENABLE;
  logic [PADDR_SIZE-1:0]          PADDR;
  logic [PDATA_SIZE/8-1:0]        PSTRB;
  logic [PDATA_SIZE-1:0]          PWDATA;
  logic                           PWRITE;
  logic [NUM_SLAVES*PDATA_SIZE-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]          PREADY;
  logic [NUM_SLAVES-1:0]          PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PADDR, PSTRB, PWDATA, PWRITE
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PADDR, PSTRB, PWDATA, PWRITE
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB4 master bridge: one outstanding command, multi-slave decode, wait states,
// ACCESS timeout and decode-error responses. All outputs come straight from flops.
module apb_master_bridge #(
  parameter int PADDR_SIZE     = 16,
  parameter int PDATA_SIZE     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  apb_master_bridge_if.master bus
);
  localparam int SEL_BITS  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_SIZE = PDATA_SIZE / 8;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic [NUM_SLAVES-1:0] onehot(input logic [SEL_BITS-1:0] i);
    logic [NUM_SLAVES-1:0] r;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      r[k] = (i == SEL_BITS'(k));
    end
    return r;
  endfunction

  state_t                  state_r, state_s;
  logic [NUM_SLAVES-1:0]   psel_r, psel_s;
  logic                    penable_r, penable_s;
  logic [PADDR_SIZE-1:0]   paddr_r, paddr_s;
  logic [PDATA_SIZE-1:0]   pwdata_r, pwdata_s;
  logic [STRB_SIZE-1:0]    pstrb_r, pstrb_s;
  logic                    pwrite_r, pwrite_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic                    cmd_ready_r, cmd_ready_s;
  logic                    rsp_valid_r, rsp_valid_s;
  logic [PDATA_SIZE-1:0]   rsp_rdata_r, rsp_rdata_s;
  logic                    rsp_err_r, rsp_err_s;
  logic                    rsp_timeout_r, rsp_timeout_s;

  logic [SEL_BITS-1:0]     dec_idx_s;
  logic                    dec_ok_s;
  logic                    sel_ready_s;
  logic                    sel_err_s;
  logic [PDATA_SIZE-1:0]   sel_rdata_s;
  logic [CNT_W:0]          cnt_inc_s;
  logic                    timeout_hit_s;

  // Address decode and selected-slave return path; psel_r is one-hot during a transfer,
  // so masking with it ignores every unselected slave.
  always_comb begin
    dec_idx_s = {SEL_BITS{1'b0}};
    if (NUM_SLAVES > 1) begin
      dec_idx_s = bus.cmd_addr[PADDR_SIZE-1 -: SEL_BITS];
    end else begin
      dec_idx_s = {SEL_BITS{1'b0}};
    end
    dec_ok_s    = ({1'b0, dec_idx_s} < (SEL_BITS + 1)'(NUM_SLAVES));
    sel_ready_s = |(bus.PREADY & psel_r);
    sel_err_s   = |(bus.PSLVERR & psel_r);
    sel_rdata_s = {PDATA_SIZE{1'b0}};
    for (int k = 0; k < NUM_SLAVES; k++) begin
      sel_rdata_s = sel_rdata_s | (bus.PRDATA[k*PDATA_SIZE +: PDATA_SIZE] & {PDATA_SIZE{psel_r[k]}});
    end
    cnt_inc_s     = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
    timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_inc_s == TO_LIMIT);
  end

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_s       = state_r;
    psel_s        = psel_r;
    penable_s     = penable_r;
    paddr_s       = paddr_r;
    pwdata_s      = pwdata_r;
    pstrb_s       = pstrb_r;
    pwrite_s      = pwrite_r;
    cnt_s         = cnt_r;
    cmd_ready_s   = cmd_ready_r;
    rsp_valid_s   = rsp_valid_r;
    rsp_rdata_s   = rsp_rdata_r;
    rsp_err_s     = rsp_err_r;
    rsp_timeout_s = rsp_timeout_r;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (bus.cmd_valid) begin
          cmd_ready_s = 1'b0;
          cnt_s       = {CNT_W{1'b0}};
          if (dec_ok_s) begin
            state_s  = ST_SETUP;
            psel_s   = onehot(dec_idx_s);
            paddr_s  = bus.cmd_addr;
            pwdata_s = bus.cmd_wdata;
            pwrite_s = bus.cmd_write;
            pstrb_s  = bus.cmd_write ? bus.cmd_strb : {STRB_SIZE{1'b0}};
          end else begin
            // Decode error: answer directly, the APB segment never sees it.
            state_s       = ST_RESP;
            rsp_valid_s   = 1'b1;
            rsp_err_s     = 1'b1;
            rsp_timeout_s = 1'b0;
            rsp_rdata_s   = {PDATA_SIZE{1'b0}};
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        penable_s = 1'b1;
        state_s   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sel_ready_s || timeout_hit_s) begin
          state_s       = ST_RESP;
          psel_s        = {NUM_SLAVES{1'b0}};
          penable_s     = 1'b0;
          pstrb_s       = {STRB_SIZE{1'b0}};
          rsp_valid_s   = 1'b1;
          rsp_err_s     = sel_ready_s ? sel_err_s : 1'b1;
          rsp_timeout_s = ~sel_ready_s;
          rsp_rdata_s   = (sel_ready_s && !pwrite_r && !sel_err_s) ? sel_rdata_s : {PDATA_SIZE{1'b0}};
        end else begin
          cnt_s = cnt_inc_s[CNT_W-1:0];
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_s       = ST_IDLE;
          cmd_ready_s   = 1'b1;
          rsp_valid_s   = 1'b0;
          rsp_err_s     = 1'b0;
          rsp_timeout_s = 1'b0;
          rsp_rdata_s   = {PDATA_SIZE{1'b0}};
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        psel_s      = {NUM_SLAVES{1'b0}};
        penable_s   = 1'b0;
        pstrb_s     = {STRB_SIZE{1'b0}};
        rsp_valid_s = 1'b0;
        cmd_ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r       <= ST_IDLE;
      psel_r        <= {NUM_SLAVES{1'b0}};
      penable_r     <= 1'b0;
      paddr_r       <= {PADDR_SIZE{1'b0}};
      pwdata_r      <= {PDATA_SIZE{1'b0}};
      pstrb_r       <= {STRB_SIZE{1'b0}};
      pwrite_r      <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      cmd_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {PDATA_SIZE{1'b0}};
      rsp_err_r     <= 1'b0;
      rsp_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      psel_r        <= psel_s;
      penable_r     <= penable_s;
      paddr_r       <= paddr_s;
      pwdata_r      <= pwdata_s;
      pstrb_r       <= pstrb_s;
      pwrite_r      <= pwrite_s;
      cnt_r         <= cnt_s;
      cmd_ready_r   <= cmd_ready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_rdata_r   <= rsp_rdata_s;
      rsp_err_r     <= rsp_err_s;
      rsp_timeout_r <= rsp_timeout_s;
    end
  end

  assign bus.PSEL        = psel_r;
  assign bus.PENABLE     = penable_r;
  assign bus.PADDR       = paddr_r;
  assign bus.PWDATA      = pwdata_r;
  assign bus.PSTRB       = pstrb_r;
  assign bus.PWRITE      = pwrite_r;
  assign bus.cmd_ready   = cmd_ready_r;
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.rsp_timeout = rsp_timeout_r;
endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Parametrised APB4 master: accepts single read/write commands on a valid/ready port, runs SETUP/ACCESS phases to one of NUM_SLAVES slaves, returns response on a valid/ready port. Adds what the existing APB interface lacks: multi-slave address decode, wait-state handling, access timeout and decode-error reporting. Sits between the internal command fabric and the peripheral APB segment.

Parameters:
PADDR_SIZE, 16, APB address width
PDATA_SIZE, 32, APB data width (multiple of 8)
NUM_SLAVES, 4, slaves on the segment (1..16); SEL_BITS = max(1, $clog2(NUM_SLAVES))
TIMEOUT_CYCLES, 16, max ACCESS cycles before abort; 0 disables timeout

Ports:
PCLK  in  1  clock
PRESETn  in  1  synchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  PADDR_SIZE  byte address
cmd_wdata  in  PDATA_SIZE  write data
cmd_strb  in  PDATA_SIZE/8  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted when valid&ready
rsp_rdata  out  PDATA_SIZE  read data (0 for writes/errors)
rsp_err  out  1  PSLVERR, timeout or decode error
rsp_timeout  out  1  error cause was timeout
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB enable
PADDR  out  PADDR_SIZE  address
PSTRB  out  PDATA_SIZE/8  strobes (0 on reads)
PWDATA  out  PDATA_SIZE  write data
PWRITE  out  1  direction
PRDATA  in  NUM_SLAVES*PDATA_SIZE  slave i read data at [i*PDATA_SIZE +: PDATA_SIZE]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (PRESETn=0 at PCLK edge): state IDLE; all outputs 0 except cmd_ready=1 in IDLE; counters cleared. Reset mid-transfer drops PSEL/PENABLE on the next edge, no response issued.
- Decode: idx = cmd_addr[PADDR_SIZE-1 -: SEL_BITS] (NUM_SLAVES=1: idx=0 always). idx >= NUM_SLAVES is a decode error.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid: latch addr/wdata/strb/write/idx. Valid idx -> SETUP; invalid -> RESP with rsp_err=1, rsp_timeout=0, no APB activity.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven (PSTRB=0 for reads). -> ACCESS.
- ACCESS: PSEL[idx]=1, PENABLE=1, all APB outputs stable. Sample PREADY[idx] each edge:
  - PREADY=1: capture PRDATA slice (reads only) and PSLVERR[idx] into rsp_err; -> RESP. Zero-wait transfer = 2 APB cycles.
  - PREADY=0: wait counter +1; if TIMEOUT_CYCLES!=0 and counter reaches TIMEOUT_CYCLES -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- RESP: PSEL=0, PENABLE=0; rsp_valid=1, rsp_* held stable until rsp_ready=1; then -> IDLE. cmd_ready=0 outside IDLE (one outstanding transfer).
- PADDR/PWDATA/PWRITE hold last value when idle; PSTRB returns 0.
- rsp_rdata forced 0 on writes and any error. PRDATA/PSLVERR from unselected slaves ignored.
- Latency cmd handshake to rsp_valid: 3 + wait states cycles; decode error: 1 cycle.

Test Plan:
- Write 0x1234_5678 strb 0xF to addr 0x0010 (slave 0), PREADY[0]=1 -> PSEL=0001 one SETUP + one ACCESS cycle, PWRITE=1, rsp_valid 3 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read addr 0x8004 (slave 2), PREADY[2] low 3 ACCESS cycles, PRDATA slice 2=0xCAFE_F00D -> PENABLE high 4 cycles, PSTRB=0, rsp_rdata=0xCAFE_F00D.
- Write slave 1 with PSLVERR[1]=1 at PREADY -> rsp_err=1, rsp_timeout=0.
- Read slave 3 with PREADY never high, TIMEOUT_CYCLES=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, PSEL=0 next cycle.
- NUM_SLAVES=3, addr 0xC000 -> no PSEL asserted, rsp_valid next cycle with rsp_err=1.
- rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0 with cmd_valid=1; PRESETn=0 during ACCESS -> PSEL/PENABLE=0 next edge, no rsp_valid.
